// File: rtl/maxpool_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_pkg
// Shared definitions for the max-pooling forward/backward blocks:
//   - state_e  : pass FSM states (idle, clear, calc, done)
//   - out_dim  : pooled output extent from input extent, kernel, stride, padding
//   - idx_w    : index width for an extent (never below 1 bit)
//   - sat_add  : signed add clamped to a dw-bit two's-complement range
// -----------------------------------------------------------------------------
package maxpool_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StCalc,
        StDone
    } state_e;

    function automatic int unsigned out_dim(input int unsigned n, input int unsigned k,
                                            input int unsigned s, input int unsigned p);
        return (n + 2 * p - k) / s + 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands are dw-bit values sign-extended to 64 bits, so the raw sum is exact.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/pool_window_argmax.sv
// -----------------------------------------------------------------------------
// pool_window_argmax
// Purely combinational argmax over one KERNEL x KERNEL pooling window.
// Scans in raster order (ih outer, iw inner); the first in-range element is the
// initial candidate and a later one replaces it only when strictly greater, so
// ties resolve to the earliest element.
// Ports:
//   win_val  in   window values, [ih][iw]
//   win_rng  in   per-element in-range flags, [ih][iw]
//   found    out  at least one element was in range
//   win_ih   out  row offset of the winner inside the window
//   win_iw   out  column offset of the winner inside the window
// -----------------------------------------------------------------------------
module pool_window_argmax
    import maxpool_pkg::*;
#(
    parameter int unsigned KERNEL = 2,
    parameter int unsigned DW     = 24,
    localparam int unsigned KW    = idx_w(KERNEL)
) (
    input  logic signed [DW-1:0] win_val [KERNEL][KERNEL],
    input  logic                 win_rng [KERNEL][KERNEL],
    output logic                 found,
    output logic [KW-1:0]        win_ih,
    output logic [KW-1:0]        win_iw
);

    logic signed [DW-1:0] best;

    always_comb begin
        found  = 1'b0;
        best   = '0;
        win_ih = '0;
        win_iw = '0;
        for (int ih = 0; ih < int'(KERNEL); ih++) begin
            for (int iw = 0; iw < int'(KERNEL); iw++) begin
                if (win_rng[ih][iw] && (!found || (win_val[ih][iw] > best))) begin
                    found  = 1'b1;
                    best   = win_val[ih][iw];
                    win_ih = KW'(ih);
                    win_iw = KW'(iw);
                end
            end
        end
    end

endmodule

// File: rtl/max_unpool2d_bwd.sv
// -----------------------------------------------------------------------------
// max_unpool2d_bwd
// Backward pass of 2-D max pooling. Each upstream gradient value is added onto
// the forward-input position that won the max of its window; all other
// positions stay zero. One window per clock, ow fastest, then oh, then c.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   valid_in   in   start request, honoured in idle/done only
//   in_data    in   forward input [CH][IN_H][IN_W], held until valid_out
//   grad_in    in   upstream gradient [CH][OUT_H][OUT_W], held until valid_out
//   busy       out  high during clear and calc
//   valid_out  out  one-cycle completion pulse, final grad_out already visible
//   grad_out   out  registered routed gradient [CH][IN_H][IN_W]
// Build option:
//   MAXUNPOOL_SAT_EN  defined: overlapping accumulation saturates to DW bits;
//                     undefined: accumulation wraps (two's complement).
// -----------------------------------------------------------------------------
module max_unpool2d_bwd
    import maxpool_pkg::*;
#(
    parameter int unsigned CH      = 1,
    parameter int unsigned IN_H    = 8,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned KERNEL  = 2,
    parameter int unsigned STRIDE  = 2,
    parameter int unsigned PADDING = 0,
    parameter int unsigned INT_W   = 8,
    parameter int unsigned FRAC_W  = 16,
    localparam int unsigned DW     = INT_W + FRAC_W,
    localparam int unsigned OUT_H  = out_dim(IN_H, KERNEL, STRIDE, PADDING),
    localparam int unsigned OUT_W  = out_dim(IN_W, KERNEL, STRIDE, PADDING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] in_data  [CH][IN_H][IN_W],
    input  logic signed [DW-1:0] grad_in  [CH][OUT_H][OUT_W],
    output logic                 busy,
    output logic                 valid_out,
    output logic signed [DW-1:0] grad_out [CH][IN_H][IN_W]
);

    localparam int unsigned KW  = idx_w(KERNEL);
    localparam int unsigned CW  = idx_w(CH);
    localparam int unsigned HW  = idx_w(IN_H);
    localparam int unsigned WW  = idx_w(IN_W);
    localparam int unsigned OHW = idx_w(OUT_H);
    localparam int unsigned OWW = idx_w(OUT_W);

    localparam int S_I = int'(STRIDE);
    localparam int P_I = int'(PADDING);
    localparam int H_I = int'(IN_H);
    localparam int W_I = int'(IN_W);

    localparam logic [CW-1:0]  C_LAST  = CW'(CH - 1);
    localparam logic [OHW-1:0] OH_LAST = OHW'(OUT_H - 1);
    localparam logic [OWW-1:0] OW_LAST = OWW'(OUT_W - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  c_q, c_d;
    logic [OHW-1:0] oh_q, oh_d;
    logic [OWW-1:0] ow_q, ow_d;
    logic           valid_q, valid_d;
    logic           clear;
    logic           step;
    logic           last_win;

    logic signed [DW-1:0] grad_q [CH][IN_H][IN_W];

    // Window origin in input coordinates; may be negative when padded.
    int                   base_r;
    int                   base_c;
    logic signed [DW-1:0] win_val [KERNEL][KERNEL];
    logic                 win_rng [KERNEL][KERNEL];

    logic          win_found;
    logic [KW-1:0] win_ih;
    logic [KW-1:0] win_iw;

    logic [HW-1:0]        sel_r;
    logic [WW-1:0]        sel_c;
    logic signed [DW-1:0] old_val;
    logic signed [DW-1:0] add_val;
    logic signed [DW-1:0] sum_val;

    // ---------------------------------------------------------------- window
    always_comb begin
        int r;
        int col;
        r       = 0;
        col     = 0;
        base_r  = int'(oh_q) * S_I - P_I;
        base_c  = int'(ow_q) * S_I - P_I;
        win_val = '{default: '0};
        win_rng = '{default: 1'b0};
        for (int ih = 0; ih < int'(KERNEL); ih++) begin
            for (int iw = 0; iw < int'(KERNEL); iw++) begin
                r   = base_r + ih;
                col = base_c + iw;
                win_rng[ih][iw] = (r >= 0) && (r < H_I) && (col >= 0) && (col < W_I);
                // Padded positions read as zero and are masked by win_rng anyway.
                win_val[ih][iw] = win_rng[ih][iw] ? in_data[c_q][HW'(r)][WW'(col)] : '0;
            end
        end
    end

    pool_window_argmax #(
        .KERNEL (KERNEL),
        .DW     (DW)
    ) u_argmax (
        .win_val (win_val),
        .win_rng (win_rng),
        .found   (win_found),
        .win_ih  (win_ih),
        .win_iw  (win_iw)
    );

    // ------------------------------------------------------------ accumulate
    always_comb begin
        sel_r   = HW'(base_r + int'(win_ih));
        sel_c   = WW'(base_c + int'(win_iw));
        old_val = grad_q[c_q][sel_r][sel_c];
        add_val = grad_in[c_q][oh_q][ow_q];
`ifdef MAXUNPOOL_SAT_EN
        sum_val = DW'(sat_add(64'(old_val), 64'(add_val), DW));
`else
        // A DW-bit add is exactly the DW+1-bit sum truncated to its low DW bits.
        sum_val = old_val + add_val;
`endif
    end

    // ------------------------------------------------------------------- fsm
    assign last_win = (c_q == C_LAST) && (oh_q == OH_LAST) && (ow_q == OW_LAST);

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        clear   = 1'b0;
        step    = 1'b0;
        c_d     = c_q;
        oh_d    = oh_q;
        ow_d    = ow_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (valid_in) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                clear   = 1'b1;
                c_d     = '0;
                oh_d    = '0;
                ow_d    = '0;
                state_d = StCalc;
            end
            StCalc: begin
                step = 1'b1;
                if (ow_q == OW_LAST) begin
                    ow_d = '0;
                    if (oh_q == OH_LAST) begin
                        oh_d = '0;
                        c_d  = (c_q == C_LAST) ? '0 : c_q + 1'b1;
                    end else begin
                        oh_d = oh_q + 1'b1;
                    end
                end else begin
                    ow_d = ow_q + 1'b1;
                end
                if (last_win) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            oh_q    <= '0;
            ow_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            oh_q    <= oh_d;
            ow_q    <= ow_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(CH); c++) begin
                for (int r = 0; r < H_I; r++) begin
                    for (int col = 0; col < W_I; col++) begin
                        grad_q[c][r][col] <= '0;
                    end
                end
            end
        end else if (clear) begin
            for (int c = 0; c < int'(CH); c++) begin
                for (int r = 0; r < H_I; r++) begin
                    for (int col = 0; col < W_I; col++) begin
                        grad_q[c][r][col] <= '0;
                    end
                end
            end
        end else if (step && win_found) begin
            grad_q[c_q][sel_r][sel_c] <= sum_val;
        end
    end

    assign grad_out  = grad_q;
    assign busy      = (state_q == StClear) || (state_q == StCalc);
    assign valid_out = valid_q;

endmodule

// File: tb/tb_max_unpool2d_bwd.sv
// -----------------------------------------------------------------------------
// tb_max_unpool2d_bwd
// Randomised scoreboard bench. Configuration with overlap and padding
// (K=3, S=2, P=1, two channels). The driver computes each pass's expected map
// from a direct reading of the routing rules and queues it with the expected
// completion cycle; the monitor checks busy/valid_out every cycle and the map
// on each completion.
// -----------------------------------------------------------------------------
module tb_max_unpool2d_bwd;

    localparam int CH    = 2;
    localparam int IH    = 5;
    localparam int IW    = 6;
    localparam int K     = 3;
    localparam int S     = 2;
    localparam int P     = 1;
    localparam int DW    = 24;
    localparam int OH    = (IH + 2 * P - K) / S + 1;
    localparam int OW    = (IW + 2 * P - K) / S + 1;
    localparam int N     = CH * OH * OW;
    localparam int NPOS  = CH * IH * IW;
    localparam int MAPW  = NPOS * DW;
    localparam int MAXV  = (1 <<< (DW - 1)) - 1;
    localparam int MINV  = -(1 <<< (DW - 1));
    localparam int NPASS = 14;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic valid_in = 1'b0;
    logic busy;
    logic valid_out;
    logic signed [DW-1:0] in_data  [CH][IH][IW];
    logic signed [DW-1:0] grad_in  [CH][OH][OW];
    logic signed [DW-1:0] grad_out [CH][IH][IW];

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [MAPW-1:0] exp_map_q[$];
    int              exp_done_q[$];

    max_unpool2d_bwd #(
        .CH      (CH),
        .IN_H    (IH),
        .IN_W    (IW),
        .KERNEL  (K),
        .STRIDE  (S),
        .PADDING (P),
        .INT_W   (8),
        .FRAC_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .in_data   (in_data),
        .grad_in   (grad_in),
        .busy      (busy),
        .valid_out (valid_out),
        .grad_out  (grad_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ----------------------------------------------------------------- model
    function automatic int fold(input int s);
`ifdef MAXUNPOOL_SAT_EN
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
`else
        int t;
        t = s & ((1 <<< DW) - 1);
        if (t > MAXV) t = t - (1 <<< DW);
        return t;
`endif
    endfunction

    function automatic logic [MAPW-1:0] model();
        int              acc [CH][IH][IW];
        logic [MAPW-1:0] m;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IH; r++)
                for (int col = 0; col < IW; col++)
                    acc[c][r][col] = 0;
        for (int c = 0; c < CH; c++) begin
            for (int oh = 0; oh < OH; oh++) begin
                for (int ow = 0; ow < OW; ow++) begin
                    bit found;
                    int br, bc, bv;
                    found = 0; br = 0; bc = 0; bv = 0;
                    for (int ih = 0; ih < K; ih++) begin
                        for (int iw = 0; iw < K; iw++) begin
                            int r, col;
                            r   = oh * S + ih - P;
                            col = ow * S + iw - P;
                            if (r >= 0 && r < IH && col >= 0 && col < IW) begin
                                if (!found || int'(in_data[c][r][col]) > bv) begin
                                    found = 1;
                                    bv    = int'(in_data[c][r][col]);
                                    br    = r;
                                    bc    = col;
                                end
                            end
                        end
                    end
                    if (found)
                        acc[c][br][bc] = fold(acc[c][br][bc] + int'(grad_in[c][oh][ow]));
                end
            end
        end
        m = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IH; r++)
                for (int col = 0; col < IW; col++)
                    m[((c * IH + r) * IW + col) * DW +: DW] = DW'(acc[c][r][col]);
        return m;
    endfunction

    function automatic logic [MAPW-1:0] dut_map();
        logic [MAPW-1:0] m;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IH; r++)
                for (int col = 0; col < IW; col++)
                    m[((c * IH + r) * IW + col) * DW +: DW] = grad_out[c][r][col];
        return m;
    endfunction

    // ---------------------------------------------------------------- checks
    task automatic check_map(input string name, input logic [MAPW-1:0] exp);
        logic [MAPW-1:0]      act;
        logic signed [DW-1:0] a, e;
        bit                   shown;
        act   = dut_map();
        shown = 0;
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < NPOS; i++) begin
                if (!shown && act[i*DW +: DW] !== exp[i*DW +: DW]) begin
                    shown = 1;
                    a = act[i*DW +: DW];
                    e = exp[i*DW +: DW];
                    $display("FAIL %s: c=%0d row=%0d col=%0d got %0d expected %0d (cycle %0d)",
                             name, i / (IH * IW), (i / IW) % IH, i % IW, a, e, cyc);
                end
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // --------------------------------------------------------------- monitor
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            logic bexp, vexp;
            bexp = 1'b0;
            vexp = 1'b0;
            if (exp_done_q.size() > 0) begin
                bexp = (cyc >= exp_done_q[0] - N - 1) && (cyc <= exp_done_q[0] - 1);
                vexp = (cyc == exp_done_q[0]);
            end
            check_bit("busy", busy, bexp);
            check_bit("valid_out", valid_out, vexp);
            if (vexp) begin
                check_map("grad_out", exp_map_q[0]);
                void'(exp_map_q.pop_front());
                void'(exp_done_q.pop_front());
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic gen_stim(input int mode);
        int mc, mr, mcol;
        mc   = int'($urandom_range(0, CH - 1));
        mr   = int'($urandom_range(0, IH - 1));
        mcol = int'($urandom_range(0, IW - 1));
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IH; r++)
                for (int col = 0; col < IW; col++)
                    case (mode)
                        0: in_data[c][r][col] = DW'($urandom_range(0, 3));
                        1: in_data[c][r][col] = DW'($urandom);
                        2: in_data[c][r][col] = DW'(7);
                        3: in_data[c][r][col] = DW'(MINV);
                        4: in_data[c][r][col] = (c == mc && r == mr && col == mcol) ? DW'(100) : '0;
                        default: in_data[c][r][col] = DW'($urandom_range(0, 1));
                    endcase
        for (int c = 0; c < CH; c++)
            for (int oh = 0; oh < OH; oh++)
                for (int ow = 0; ow < OW; ow++)
                    case (mode)
                        1: grad_in[c][oh][ow] = DW'(int'($urandom_range(0, 50)) - 25);
                        4: grad_in[c][oh][ow] = DW'(MAXV);
                        5: grad_in[c][oh][ow] = DW'(MINV);
                        default: grad_in[c][oh][ow] = DW'($urandom);
                    endcase
    endtask

    // Ends on the falling edge of the cycle in which valid_out is expected.
    task automatic issue(input logic [MAPW-1:0] exp);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_map_q.push_back(exp);
        exp_done_q.push_back(cyc + N + 1);
        repeat (N + 1) begin
            valid_in = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MAPW-1:0] cur;
        int              gap;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IH; r++)
                for (int col = 0; col < IW; col++)
                    in_data[c][r][col] = '0;
        for (int c = 0; c < CH; c++)
            for (int oh = 0; oh < OH; oh++)
                for (int ow = 0; ow < OW; ow++)
                    grad_in[c][oh][ow] = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("busy_reset", busy, 1'b0);
        check_bit("valid_reset", valid_out, 1'b0);
        check_map("grad_reset", '0);
        rst = 1'b0;
        @(negedge clk);

        // Random passes; gap 0 is a back-to-back restart during valid_out.
        for (int p = 0; p < NPASS; p++) begin
            gen_stim(p % 6);
            cur = model();
            issue(cur);
            gap = (p == NPASS - 1) ? 2 : int'($urandom_range(0, 2));
            if (gap > 0) begin
                valid_in = 1'b0;
                repeat (gap) @(negedge clk);
                check_map("grad_hold", cur);
            end
        end

        // Reset a few cycles into CALC.
        gen_stim(0);
        cur = model();
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_map_q.push_back(cur);
        exp_done_q.push_back(cyc + N + 1);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_map_q.delete();
        exp_done_q.delete();
        #1;
        check_bit("busy_mid_reset", busy, 1'b0);
        check_bit("valid_mid_reset", valid_out, 1'b0);
        check_map("grad_mid_reset", '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        gen_stim(4);
        cur = model();
        issue(cur);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_map("grad_after_reset", cur);

        n_checks++;
        if (exp_map_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_passes: got %0d outstanding expected 0", exp_map_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/max_unpool2d_bwd.md
# max_unpool2d_bwd

Backward pass of our 2-D max-pooling layer.
- Accepts the forward-pass input feature map and the upstream gradient, one value per pooled output.
- Routes each gradient value to the position that won the max in its pooling window; every other position receives zero.
- Processes one window per clock, sequentially over channel, output row and output column.
- Sits between the gradient source of the next layer and the gradient input of the preceding convolution layer.

## Interface
- CH, 1, channel count
- IN_H, 8, forward input height
- IN_W, 8, forward input width
- KERNEL, 2, window side length
- STRIDE, 2, window step
- PADDING, 0, implicit border width; must be less than KERNEL
- INT_W, 8, integer bits of the signed fixed-point format
- FRAC_W, 16, fractional bits
- Derived: DW = INT_W+FRAC_W; OUT_H = (IN_H+2*PADDING-KERNEL)/STRIDE+1; OUT_W likewise from IN_W
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- valid_in  in  1  request to start a backward pass
- in_data  in  signed DW [CH][IN_H][IN_W]  forward input; must be held stable from the accepting edge until valid_out
- grad_in  in  signed DW [CH][OUT_H][OUT_W]  upstream gradient; same stability rule as in_data
- busy  out  1  high while in CLEAR or CALC
- valid_out  out  1  one-cycle completion pulse
- grad_out  out  signed DW [CH][IN_H][IN_W]  routed gradient, registered

## Operation
- States and transitions:
  - IDLE: valid_in → CLEAR.
  - CLEAR: one cycle. Zeroes all of grad_out and resets indices c/oh/ow to 0. → CALC.
  - CALC: one window per cycle; after the last window → DONE.
  - DONE: valid_in → CLEAR, otherwise stay in DONE.
- valid_in is ignored in CLEAR and CALC. There is no queueing.
- Window (c,oh,ow) covers r = oh*STRIDE+ih-PADDING and col = ow*STRIDE+iw-PADDING, for ih,iw in 0..KERNEL-1.
- Positions outside the input are never selected.
- Argmax: the first in-range element in raster order (ih outer, iw inner) is the initial candidate. A later element replaces it only if it is strictly greater, so ties go to the earliest element.
  - An all-most-negative window still selects its first in-range element.
- Write: grad_out[c][r*][col*] <= grad_out[c][r*][col*] + grad_in[c][oh][ow].
  - Accumulation matters when STRIDE<KERNEL, because windows overlap.
  - The sum is computed at DW+1 bits and then reduced to DW bits (see Configuration).
- Index advance order: ow fastest, then oh, then c. This matches the forward pass.
- grad_out holds its value through DONE and IDLE until the next CLEAR.

## Timing
- Reset values: state IDLE, c/oh/ow 0, busy 0, valid_out 0, grad_out all 0. Reset applied mid-pass aborts immediately; no partial result is flagged.
- Let N = CH*OUT_H*OUT_W. With the accepting edge at E0:
  - CLEAR occupies E0..E1.
  - CALC writes occur at edges E2..E(N+1).
  - valid_out is high for exactly the cycle between E(N+1) and E(N+2), with the final grad_out already visible.
- Latency from the accepting edge to valid_out = N+1 cycles. Throughput = one pass per N+2 cycles.
- Back-to-back: valid_in high during the valid_out cycle is accepted. The next CLEAR follows immediately.
- busy rises the cycle after the accepting edge. It falls in the same cycle valid_out rises.

## Configuration
- MAXUNPOOL_SAT_EN defined: an overlapping accumulation that leaves the DW-bit range clamps to 2^(DW-1)-1 or -2^(DW-1).
- Undefined: the sum is truncated to its low DW bits, i.e. two's-complement wrap.
- With STRIDE>=KERNEL there is no overlap, so both builds behave identically.

## Structure
- Shared package maxpool_pkg holds:
  - the state enum (IDLE, CLEAR, CALC, DONE);
  - the OUT_H/OUT_W computation function;
  - the saturating-add function, used by this block and reusable by the forward block.
- Sub-module pool_window_argmax, purely combinational:
  - inputs: the window's KERNEL×KERNEL values plus in-range flags;
  - outputs: found flag plus ih/iw of the winner.
- The top level holds the FSM, index counters and grad_out registers.

## Test plan
- Basic routing. CH=1, 4×4, K=2, S=2; in_data rows {1,5,2,0},{3,4,8,7},{0,0,1,1},{9,2,1,6}; grad_in {10,20,30,40} → grad_out is 10 at (0,1), 20 at (1,2), 30 at (3,0), 40 at (3,3), all else 0. valid_out pulses 5 cycles after the accepting edge.
- Tie-break. A window of all 7s with grad 3 → 3 only at the window's top-left position.
- Overlap. K=3, S=1, 4×4, a single global max 100 at (1,1), grad_in all 0x7FFFFF:
  - with MAXUNPOOL_SAT_EN: grad_out(1,1)=0x7FFFFF;
  - without: grad_out(1,1)=0xFFFFFC (the wrapped sum).
- Padding. K=2, S=2, P=1, all in_data=-8388608 → each output's gradient lands on the first in-range element; padded positions are never written.
- Reset mid-CALC. Assert rst 3 cycles into CALC → busy=0, valid_out=0, grad_out all 0, state IDLE. A subsequent pass completes normally.
- Back-to-back. valid_in held high → second CLEAR starts the cycle after valid_out; valid_out pulses every N+2 cycles. valid_in pulses during CALC are ignored.
